// File: rtl/spi_pkg.sv
// Shared SPI definitions: master FSM state encodings and bus mode constants,
// common to master- and slave-side code.
package spi_pkg;

   localparam logic [2:0] ST_IDLE    = 3'd0;
   localparam logic [2:0] ST_ASSERT  = 3'd1;
   localparam logic [2:0] ST_SHIFT   = 3'd2;
   localparam logic [2:0] ST_WAIT    = 3'd3;
   localparam logic [2:0] ST_RELEASE = 3'd4;

   // SPI mode 0: sclk idles low, data sampled on the rising edge.
   localparam logic SPI_CPOL = 1'b0;
   localparam logic SPI_CPHA = 1'b0;

   localparam int SPI_BITS = 8;

endpackage

// File: rtl/spi_clkgen.sv
// sclk divider: counts CLK_DIV clk cycles per half-period and flags the
// cycles that launch each sclk rising/falling edge.
module spi_clkgen
   import spi_pkg::*;
#(
   parameter int CLK_DIV = 4
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clr,
   input  logic en,
   output logic tick,
   output logic rise_stb,
   output logic fall_stb,
   output logic sclk
);

   localparam int CW = $clog2(CLK_DIV + 1);

   logic [CW-1:0] cnt_q, cnt_d;
   logic          sclk_q, sclk_d;

   assign tick     = (cnt_q == CW'(CLK_DIV - 1));
   assign rise_stb = en && tick && (sclk_q == SPI_CPOL);
   assign fall_stb = en && tick && (sclk_q != SPI_CPOL);
   assign sclk     = sclk_q;

   always_comb begin
      cnt_d  = (clr || tick) ? '0 : cnt_q + CW'(1);
      sclk_d = sclk_q;
      if (clr || !en) begin
         sclk_d = SPI_CPOL;
      end else if (tick) begin
         sclk_d = ~sclk_q;
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every flop
   // samples pre-edge values regardless of block ordering.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q  <= '0;
         sclk_q <= SPI_CPOL;
      end else begin
         cnt_q  <= cnt_d;
         sclk_q <= sclk_d;
      end
   end

endmodule

// File: rtl/spi_master.sv
// SPI mode-0 master: byte-wide valid/ready transmit, simultaneous receive,
// cs_n held across bytes until a byte tagged tx_last completes.
module spi_master
   import spi_pkg::*;
#(
   parameter int CLK_DIV = 4
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [7:0] tx_data,
   input  logic       tx_valid,
   input  logic       tx_last,
   output logic       tx_ready,
   output logic [7:0] rx_data,
   output logic       rx_valid,
   output logic       busy,
   output logic       sclk,
   output logic       cs_n,
   output logic       mosi,
   input  logic       miso
);

   logic [2:0] state_q, state_d;
   logic [3:0] edge_q, edge_d;
   logic [7:0] tx_sr_q, tx_sr_d;
   logic [7:0] rx_sr_q, rx_sr_d;
   logic [7:0] rx_data_q, rx_data_d;
   logic       last_q, last_d;
   logic       cs_n_q, cs_n_d;
   logic       mosi_q, mosi_d;
   logic       rx_valid_q, rx_valid_d;
   logic       tx_ready_q, tx_ready_d;
   logic       tick, rise_stb, fall_stb, clr, accept, shift_en;

   assign accept   = tx_valid && tx_ready_q;
   assign clr      = (state_d != state_q);
   assign shift_en = (state_q == ST_SHIFT);

   spi_clkgen #(.CLK_DIV(CLK_DIV)) u_clkgen (
      .clk      (clk),
      .rst_n    (rst_n),
      .clr      (clr),
      .en       (shift_en),
      .tick     (tick),
      .rise_stb (rise_stb),
      .fall_stb (fall_stb),
      .sclk     (sclk)
   );

   // NOTE: every always_comb output gets a default first, so no path can
   // leave it unassigned and infer a latch.
   always_comb begin
      state_d    = state_q;
      edge_d     = edge_q;
      tx_sr_d    = tx_sr_q;
      rx_sr_d    = rx_sr_q;
      rx_data_d  = rx_data_q;
      last_d     = last_q;
      cs_n_d     = cs_n_q;
      mosi_d     = mosi_q;
      rx_valid_d = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (accept) begin
               tx_sr_d = tx_data;
               last_d  = tx_last;
               mosi_d  = tx_data[SPI_BITS-1];
               cs_n_d  = 1'b0;
               state_d = ST_ASSERT;
            end
         end
         ST_ASSERT: begin
            if (tick) state_d = ST_SHIFT;
         end
         ST_SHIFT: begin
            if (rise_stb) rx_sr_d = {rx_sr_q[6:0], miso};
            if (tick) edge_d = edge_q + 4'd1;
            // edge_q == 15 marks the 8th falling edge: byte complete.
            if (fall_stb) begin
               if (edge_q == 4'd15) begin
                  rx_data_d  = rx_sr_q;
                  rx_valid_d = 1'b1;
                  state_d    = last_q ? ST_RELEASE : ST_WAIT;
               end else begin
                  mosi_d  = tx_sr_q[6];
                  tx_sr_d = {tx_sr_q[6:0], 1'b0};
               end
            end
         end
         ST_WAIT: begin
            if (accept) begin
               tx_sr_d = tx_data;
               last_d  = tx_last;
               mosi_d  = tx_data[SPI_BITS-1];
               state_d = ST_SHIFT;
            end
         end
         ST_RELEASE: begin
            // Edge counter doubles as phase: 0 = cs_n low hold, 1 = cs_n high gap.
            if (tick) begin
               if (edge_q == 4'd0) begin
                  cs_n_d = 1'b1;
                  edge_d = 4'd1;
               end else begin
                  mosi_d  = 1'b0;
                  state_d = ST_IDLE;
               end
            end
         end
         default: begin
            cs_n_d  = 1'b1;
            mosi_d  = 1'b0;
            state_d = ST_IDLE;
         end
      endcase

      if (state_d != state_q) edge_d = '0;
      tx_ready_d = (state_d == ST_IDLE) || (state_d == ST_WAIT);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_IDLE;
         edge_q     <= '0;
         tx_sr_q    <= '0;
         rx_sr_q    <= '0;
         rx_data_q  <= '0;
         last_q     <= 1'b0;
         cs_n_q     <= 1'b1;
         mosi_q     <= 1'b0;
         rx_valid_q <= 1'b0;
         tx_ready_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         edge_q     <= edge_d;
         tx_sr_q    <= tx_sr_d;
         rx_sr_q    <= rx_sr_d;
         rx_data_q  <= rx_data_d;
         last_q     <= last_d;
         cs_n_q     <= cs_n_d;
         mosi_q     <= mosi_d;
         rx_valid_q <= rx_valid_d;
         tx_ready_q <= tx_ready_d;
      end
   end

   assign tx_ready = tx_ready_q;
   assign rx_data  = rx_data_q;
   assign rx_valid = rx_valid_q;
   assign cs_n     = cs_n_q;
   assign mosi     = mosi_q;
   assign busy     = (state_q != ST_IDLE);

endmodule

// File: tb/tb_spi_master.sv
// Self-checking bench for spi_master: CLK_DIV=4 instance for the main
// scenarios, CLK_DIV=2 instance for back-to-back framing and sclk period.
module tb_spi_master;

   logic       clk = 1'b0;
   logic       rst_n;

   logic [7:0] tx_data;
   logic       tx_valid, tx_last, tx_ready;
   logic [7:0] rx_data;
   logic       rx_valid, busy, sclk, cs_n, mosi, miso;
   logic       miso_sel;
   logic [7:0] slave_sr = 8'h5A;

   logic [7:0] t2_data;
   logic       t2_valid, t2_last, t2_ready;
   logic [7:0] r2_data;
   logic       r2_valid, busy2, sclk2, cs2_n, mosi2;

   int n_checks = 0;
   int n_fail   = 0;

   logic [7:0] sb1[$];
   logic [7:0] sb2[$];

   // Monitor state, DUT 1
   logic        prev_sclk = 1'b0, prev_cs = 1'b1;
   int          rise_cnt = 0, cs_len = 0, cs_last_len = 0, cs_rise_cnt = 0;
   int          acc_cnt = 0, rx_cnt = 0;
   logic [15:0] mosi_bits = '0;

   // Monitor state, DUT 2
   logic prev_sclk2 = 1'b0, prev_cs2 = 1'b1;
   int   hi2 = 0, gap2 = 0, lo2 = 0, lo2_last = 0;
   int   rise2 = 0, since_rise2 = 0, per_min = 1000, per_max = 0;

   always #5 clk = ~clk;

   assign miso = miso_sel ? slave_sr[7] : mosi;

   // Mode-0 slave: preloaded while deselected, shifts on each sclk fall.
   always @(negedge sclk or posedge cs_n) begin
      if (cs_n) slave_sr <= 8'h5A;
      else      slave_sr <= {slave_sr[6:0], 1'b0};
   end

   spi_master #(.CLK_DIV(4)) u_dut (
      .clk(clk), .rst_n(rst_n), .tx_data(tx_data), .tx_valid(tx_valid),
      .tx_last(tx_last), .tx_ready(tx_ready), .rx_data(rx_data),
      .rx_valid(rx_valid), .busy(busy), .sclk(sclk), .cs_n(cs_n),
      .mosi(mosi), .miso(miso)
   );

   spi_master #(.CLK_DIV(2)) u_dut2 (
      .clk(clk), .rst_n(rst_n), .tx_data(t2_data), .tx_valid(t2_valid),
      .tx_last(t2_last), .tx_ready(t2_ready), .rx_data(r2_data),
      .rx_valid(r2_valid), .busy(busy2), .sclk(sclk2), .cs_n(cs2_n),
      .mosi(mosi2), .miso(mosi2)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   always @(negedge clk) begin
      prev_sclk <= sclk;
      prev_cs   <= cs_n;
      if (sclk && !prev_sclk) begin
         rise_cnt  <= rise_cnt + 1;
         mosi_bits <= {mosi_bits[14:0], mosi};
      end
      if (!cs_n) begin
         cs_len <= cs_len + 1;
      end else if (!prev_cs) begin
         cs_last_len <= cs_len;
         cs_len      <= 0;
         cs_rise_cnt <= cs_rise_cnt + 1;
      end
      if (tx_valid && tx_ready) acc_cnt <= acc_cnt + 1;
      if (rx_valid) begin
         rx_cnt <= rx_cnt + 1;
         if (sb1.size() > 0) check("rx_data", {24'd0, rx_data}, {24'd0, sb1.pop_front()});
         else                check("rx_unexpected", {31'd0, rx_valid}, 32'd0);
      end
   end

   always @(negedge clk) begin
      prev_sclk2  <= sclk2;
      prev_cs2    <= cs2_n;
      since_rise2 <= since_rise2 + 1;
      if (cs2_n) hi2 <= hi2 + 1;
      else       hi2 <= 0;
      if (!cs2_n && prev_cs2) gap2 <= hi2;
      if (!cs2_n) begin
         lo2 <= lo2 + 1;
      end else if (!prev_cs2) begin
         lo2_last <= lo2;
         lo2      <= 0;
      end
      if (sclk2 && !prev_sclk2) begin
         since_rise2 <= 1;
         if (rise2 % 8 != 0) begin
            if (since_rise2 < per_min) per_min <= since_rise2;
            if (since_rise2 > per_max) per_max <= since_rise2;
         end
         rise2 <= rise2 + 1;
      end
      if (r2_valid) begin
         if (sb2.size() > 0) check("rx2_data", {24'd0, r2_data}, {24'd0, sb2.pop_front()});
         else                check("rx2_unexpected", {31'd0, r2_valid}, 32'd0);
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [7:0] d, input logic l, input bit hold, input logic [7:0] exp_rx);
      bit ok = 1'b0;
      tx_data  = d;
      tx_last  = l;
      tx_valid = 1'b1;
      for (int n = 0; n < 400; n++) begin
         if (tx_ready) begin ok = 1'b1; break; end
         step();
      end
      check("accept_wait", {31'd0, ok}, 32'd1);
      if (ok) sb1.push_back(exp_rx);
      step();
      if (!hold) tx_valid = 1'b0;
      tx_data = ~d;
   endtask

   task automatic send2(input logic [7:0] d, input bit hold);
      bit ok = 1'b0;
      t2_data  = d;
      t2_last  = 1'b1;
      t2_valid = 1'b1;
      for (int n = 0; n < 400; n++) begin
         if (t2_ready) begin ok = 1'b1; break; end
         step();
      end
      check("accept2_wait", {31'd0, ok}, 32'd1);
      if (ok) sb2.push_back(d);
      step();
      if (!hold) t2_valid = 1'b0;
   endtask

   task automatic wait_done();
      bit ok = 1'b0;
      for (int n = 0; n < 1000; n++) begin
         if (!busy && !busy2 && sb1.size() == 0 && sb2.size() == 0) begin ok = 1'b1; break; end
         step();
      end
      check("done_wait", {31'd0, ok}, 32'd1);
      repeat (2) step();
   endtask

   initial begin
      int b_rise, b_csr, b_rx, b_acc;
      bit ok;
      rst_n = 1'b1; miso_sel = 1'b0;
      tx_data = '0; tx_valid = 1'b0; tx_last = 1'b0;
      t2_data = '0; t2_valid = 1'b0; t2_last = 1'b0;

      // Reset values
      #2 rst_n = 1'b0;
      #1;
      check("rst_cs_n", {31'd0, cs_n}, 32'd1);
      check("rst_sclk", {31'd0, sclk}, 32'd0);
      check("rst_mosi", {31'd0, mosi}, 32'd0);
      check("rst_busy", {31'd0, busy}, 32'd0);
      check("rst_rx_valid", {31'd0, rx_valid}, 32'd0);
      check("rst_rx_data", {24'd0, rx_data}, 32'd0);
      repeat (2) step();
      check("rst_tx_ready", {31'd0, tx_ready}, 32'd0);
      rst_n = 1'b1;
      step();
      check("tx_ready_after_rst", {31'd0, tx_ready}, 32'd1);

      // Single byte 0xA5, loopback
      b_rise = rise_cnt; b_csr = cs_rise_cnt; b_rx = rx_cnt;
      send(8'hA5, 1'b1, 1'b0, 8'hA5);
      wait_done();
      check("a5_cs_low_len", cs_last_len, 72);
      check("a5_sclk_pulses", rise_cnt - b_rise, 8);
      check("a5_rx_pulses", rx_cnt - b_rx, 1);
      check("a5_cs_frames", cs_rise_cnt - b_csr, 1);
      check("a5_mosi", {24'd0, mosi_bits[7:0]}, 32'hA5);
      check("a5_rx_hold", {24'd0, rx_data}, 32'hA5);

      // Two bytes under one cs_n frame, tx_valid held
      b_csr = cs_rise_cnt; b_rx = rx_cnt;
      send(8'h3C, 1'b0, 1'b1, 8'h3C);
      send(8'hC3, 1'b1, 1'b0, 8'hC3);
      wait_done();
      check("pair_cs_frames", cs_rise_cnt - b_csr, 1);
      check("pair_cs_low_len", cs_last_len, 137);
      check("pair_mosi_order", {16'd0, mosi_bits}, 32'h3CC3);
      check("pair_rx_pulses", rx_cnt - b_rx, 2);

      // Slave returns 0x5A while master sends 0xFF
      miso_sel = 1'b1;
      send(8'hFF, 1'b1, 1'b0, 8'h5A);
      wait_done();
      check("slave_mosi", {24'd0, mosi_bits[7:0]}, 32'hFF);
      miso_sel = 1'b0;

      // Reset after the 4th sclk rising edge
      b_rise = rise_cnt; b_rx = rx_cnt;
      send(8'h81, 1'b1, 1'b0, 8'h81);
      ok = 1'b0;
      for (int n = 0; n < 200; n++) begin
         if (rise_cnt >= b_rise + 4) begin ok = 1'b1; break; end
         step();
      end
      check("rise4_wait", {31'd0, ok}, 32'd1);
      rst_n = 1'b0;
      #1;
      check("midrst_cs_n", {31'd0, cs_n}, 32'd1);
      check("midrst_sclk", {31'd0, sclk}, 32'd0);
      check("midrst_busy", {31'd0, busy}, 32'd0);
      check("midrst_rx_data", {24'd0, rx_data}, 32'd0);
      sb1.delete();
      repeat (3) step();
      rst_n = 1'b1;
      repeat (80) step();
      check("midrst_no_rx_valid", rx_cnt - b_rx, 0);
      send(8'h81, 1'b1, 1'b0, 8'h81);
      wait_done();
      check("post_rst_rx_data", {24'd0, rx_data}, 32'h81);
      check("post_rst_rx_pulses", rx_cnt - b_rx, 1);

      // Random tx_valid/tx_data activity while shifting
      b_acc = acc_cnt; b_rx = rx_cnt;
      send(8'h96, 1'b1, 1'b0, 8'h96);
      for (int n = 0; n < 50; n++) begin
         tx_valid = 1'($urandom);
         tx_data  = 8'($urandom);
         step();
      end
      tx_valid = 1'b0;
      wait_done();
      check("noise_accepts", acc_cnt - b_acc, 1);
      check("noise_mosi", {24'd0, mosi_bits[7:0]}, 32'h96);
      check("noise_rx_pulses", rx_cnt - b_rx, 1);

      // CLK_DIV=2: back-to-back single-byte frames
      send2(8'h6B, 1'b1);
      send2(8'hD4, 1'b0);
      wait_done();
      check("div2_cs_gap", gap2, 3);
      check("div2_sclk_period_min", per_min, 4);
      check("div2_sclk_period_max", per_max, 4);
      check("div2_cs_low_len", lo2_last, 36);
      check("div2_rx_last", {24'd0, r2_data}, 32'hD4);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/spi_master.md
SPI_MASTER -- requirements
Module: spi_master

Interface
REQ-001 SHALL have parameter CLK_DIV, default 4, clk cycles per sclk half-period (legal range 2..255).
REQ-002 SHALL have port clk, input, 1, system clock; all logic on its rising edge.
REQ-003 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-004 SHALL have port tx_data, input, 8, byte to transmit, MSB first.
REQ-005 SHALL have port tx_valid, input, 1, tx_data valid.
REQ-006 SHALL have port tx_last, input, 1, sampled with tx_data: deassert cs_n after this byte.
REQ-007 SHALL have port tx_ready, output, 1, byte accepted on a clk edge where tx_valid && tx_ready.
REQ-008 SHALL have port rx_data, output, 8, byte captured from miso.
REQ-009 SHALL have port rx_valid, output, 1, one-cycle strobe marking rx_data updated.
REQ-010 SHALL have port busy, output, 1, high whenever the state is not IDLE.
REQ-011 SHALL have ports sclk (output, 1), cs_n (output, 1, active low), mosi (output, 1) and miso (input, 1) for SPI mode 0.

Function
REQ-012 SHALL implement states IDLE, ASSERT, SHIFT, WAIT and RELEASE.
REQ-013 SHALL assert tx_ready only in IDLE and WAIT.
REQ-014 On acceptance in IDLE, SHALL latch tx_data/tx_last, drive cs_n=0 and mosi=bit7 next cycle, and enter ASSERT for CLK_DIV cycles.
REQ-015 On acceptance in WAIT, SHALL latch the byte, drive mosi=bit7 next cycle, and enter SHIFT directly with cs_n held low.
REQ-016 In SHIFT, SHALL toggle sclk every CLK_DIV cycles starting low: 8 rising and 8 falling edges, 16*CLK_DIV cycles total.
REQ-017 SHALL sample miso on the clk cycle that drives each sclk rising edge and shift it into rx bits, MSB first.
REQ-018 SHALL present the next tx bit on mosi on each sclk falling edge except the 8th.
REQ-019 After the 8th falling edge, SHALL load rx_data and pulse rx_valid for exactly one cycle.
REQ-020 In that same cycle, SHALL go to RELEASE if the latched tx_last=1, else to WAIT.
REQ-021 In WAIT, SHALL hold cs_n=0 and sclk=0 indefinitely until tx_valid.
REQ-022 In RELEASE, SHALL hold cs_n=0 for CLK_DIV cycles, then drive cs_n=1 and stay in RELEASE a further CLK_DIV cycles (minimum cs_n high gap) before IDLE.
REQ-023 SHALL idle with sclk=0, cs_n=1, mosi=0.
REQ-024 SHALL ignore tx_valid when tx_ready=0; tx_data changes after acceptance SHALL NOT affect the byte in flight.
REQ-025 SHALL use a divider counter of width ceil(log2(CLK_DIV+1)) and a 4-bit edge counter, both cleared on every state entry.
REQ-026 rx_data SHALL hold its value until the next rx_valid.

Reset
REQ-027 While rst_n=0, SHALL force immediately (asynchronously) state=IDLE, sclk=0, cs_n=1, mosi=0, tx_ready=0, rx_valid=0, rx_data=0x00, busy=0.
REQ-028 SHALL assert tx_ready the first clk edge after rst_n rises.
REQ-029 On reset mid-transfer, SHALL discard the partial byte with no rx_valid.

Structure
REQ-030 SHALL place state encodings and SPI mode constants (CPOL=0, CPHA=0) in shared package spi_pkg, also used by spiSlave-side code.
REQ-031 SHALL instantiate a sub-module spi_clkgen (divider plus edge strobes rise_stb/fall_stb); the FSM and shift registers stay in spi_master.

Verification
REQ-032 With CLK_DIV=4, send 0xA5 with tx_last=1 and miso looped to mosi -> rx_data=0xA5, one rx_valid pulse, cs_n low exactly 72 cycles, 8 sclk pulses.
REQ-033 Send 0x3C (tx_last=0) then 0xC3 (tx_last=1) with tx_valid held -> cs_n stays low across both bytes, mosi bit order 0,0,1,1,1,1,0,0 then 1,1,0,0,0,0,1,1.
REQ-034 Drive miso from a slave model returning 0x5A while sending 0xFF -> rx_data=0x5A.
REQ-035 Assert rst_n=0 after the 4th sclk rising edge -> cs_n=1 and sclk=0 within the same cycle, no rx_valid; a following 0x81 transfer completes correctly.
REQ-036 Toggle tx_valid and tx_data randomly during SHIFT -> no extra acceptance, transmitted byte unchanged.
REQ-037 With CLK_DIV=2, two back-to-back tx_last=1 transfers -> cs_n high at least 2 cycles between them, sclk period 4 cycles.
